// File: rtl/pio_avmm_master_pkg.sv
// Shared definitions for the PIO Avalon-MM master:
// command opcodes, PIO register addresses and FSM states.
package pio_avmm_master_pkg;

    localparam logic [1:0] OP_WR_DATA = 2'b00;
    localparam logic [1:0] OP_WR_DIR  = 2'b01;
    localparam logic [1:0] OP_RD_DATA = 2'b10;
    localparam logic [1:0] OP_RD_DIR  = 2'b11;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_CAP
    } state_e;

endpackage

// File: rtl/pio_poll_timer.sv
// Background poll timer: reloading down-counter plus a sticky
// pending flag that is held until the master starts the poll read.
module pio_poll_timer
    import pio_avmm_master_pkg::*;
#(
    parameter int POLL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              poll_en,
    input  logic [POLL_W-1:0] poll_period,
    input  logic              poll_start,
    output logic              poll_pending
);

    logic [POLL_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              expire;

    always_comb begin
        expire = poll_en && (cnt_q == '0) && (poll_period != '0);
        if (!poll_en || cnt_q == '0) begin
            cnt_d = poll_period;
        end else begin
            cnt_d = cnt_q - POLL_W'(1);
        end
        // An expiry in the start cycle re-arms, later ones merge.
        pend_d = pend_q;
        if (poll_start) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= poll_period;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign poll_pending = pend_q;

endmodule

// File: rtl/pio_avmm_master.sv
// Command/poll front end driving an Avalon-MM PIO slave; reads
// have one cycle of slave latency and polls raise a sticky edge flag.
module pio_avmm_master
    import pio_avmm_master_pkg::*;
#(
    parameter int POLL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_data,
    input  logic              poll_en,
    input  logic [POLL_W-1:0] poll_period,
    output logic              edge_irq,
    input  logic              irq_clear,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata
);

    state_e     state_q, state_d;
    logic       cs_q, cs_d;
    logic       wn_q, wn_d;
    logic [1:0] addr_q, addr_d;
    logic       wdata_q, wdata_d;
    logic       poll_q, poll_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_data_q, rsp_data_d;
    logic       last_q, last_d;
    logic       first_q, first_d;
    logic       irq_q, irq_d;
    logic       en_q;
    logic       poll_pending;
    logic       poll_start;
    logic       irq_set;
    logic       rd_bit;
    logic       unused_rd;

    assign rd_bit    = avm_readdata[0];
    assign unused_rd = ^avm_readdata[31:1];

    pio_poll_timer #(
        .POLL_W(POLL_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .poll_en     (poll_en),
        .poll_period (poll_period),
        .poll_start  (poll_start),
        .poll_pending(poll_pending)
    );

    always_comb begin
        state_d     = state_q;
        cs_d        = 1'b0;
        wn_d        = 1'b1;
        addr_d      = ADDR_DATA;
        wdata_d     = 1'b0;
        poll_d      = poll_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        last_d      = last_q;
        first_d     = first_q;
        poll_start  = 1'b0;
        irq_set     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    poll_d = 1'b0;
                    cs_d   = 1'b1;
                    addr_d = cmd_op[0] ? ADDR_DIR : ADDR_DATA;
                    if (cmd_op[1]) begin
                        state_d = RD_ADDR;
                    end else begin
                        state_d = WR;
                        wn_d    = 1'b0;
                        wdata_d = cmd_wdata;
                    end
                end else if (poll_pending) begin
                    poll_start = 1'b1;
                    poll_d     = 1'b1;
                    state_d    = RD_ADDR;
                    cs_d       = 1'b1;
                    addr_d     = ADDR_DATA;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD_ADDR: begin
                state_d = RD_CAP;
                cs_d    = 1'b1;
                addr_d  = addr_q;
            end
            RD_CAP: begin
                state_d = IDLE;
                if (poll_q) begin
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (rd_bit != last_q) begin
                        irq_set = 1'b1;
                    end
                    last_d = rd_bit;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_bit;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Re-enabling polling restarts the baseline sample.
        if (poll_en && !en_q) begin
            first_d = 1'b1;
        end
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= ADDR_DATA;
            wdata_q     <= 1'b0;
            poll_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
            last_q      <= 1'b0;
            first_q     <= 1'b1;
            irq_q       <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            poll_q      <= poll_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            last_q      <= last_d;
            first_q     <= first_d;
            irq_q       <= irq_d;
            en_q        <= poll_en;
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign edge_irq       = irq_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = {31'b0, wdata_q};

endmodule

// File: tb/tb_pio_avmm_master.sv
// Bench for pio_avmm_master: PIO slave model, directed bus-timing
// steps, randomized command traffic and polling/edge-flag scenarios.
module tb_pio_avmm_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_wdata;
    logic        rsp_valid;
    logic        rsp_data;
    logic        poll_en;
    logic [15:0] poll_period;
    logic        edge_irq;
    logic        irq_clear;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'b0;

    logic pin = 1'b0;
    logic data_reg = 1'b0;
    logic dir_reg = 1'b0;
    logic data_m = 1'b0;
    logic dir_m = 1'b0;
    int   rd_m = 0;
    int   rsp_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pio_avmm_master #(
        .POLL_W(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .poll_en       (poll_en),
        .poll_period   (poll_period),
        .edge_irq      (edge_irq),
        .irq_clear     (irq_clear),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata)
    );

    // PIO slave: registered readdata, data address reads the pin.
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n) begin
            avm_readdata <= {31'b0, (avm_address == 2'd0) ? pin : dir_reg};
        end else begin
            avm_readdata <= 32'b0;
        end
        if (avm_chipselect && !avm_write_n) begin
            if (avm_address == 2'd0) data_reg <= avm_writedata[0];
            else                     dir_reg  <= avm_writedata[0];
        end
    end

    always @(posedge clk) begin
        if (rsp_valid) rsp_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic wd);
        int   n;
        logic exp;
        exp       = op[0] ? dir_m : pin;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chkb("accept_timeout", n < 20, 1'b1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_wdata = 1'($urandom);
        chkb("cs_k1", avm_chipselect, 1'b1);
        chkw("addr_k1", 32'(avm_address), 32'(op[0]));
        chkb("ready_k1", cmd_ready, 1'b0);
        if (!op[1]) begin
            chkb("wn_wr", avm_write_n, 1'b0);
            chkw("wdata_wr", avm_writedata, 32'(wd));
            if (op[0]) dir_m = wd;
            else       data_m = wd;
            tick();
            chkb("cs_after_wr", avm_chipselect, 1'b0);
            chkb("ready_after_wr", cmd_ready, 1'b1);
            chkb("norsp_wr", rsp_valid, 1'b0);
        end else begin
            rd_m++;
            chkb("wn_rd_k1", avm_write_n, 1'b1);
            chkb("rsp_k1", rsp_valid, 1'b0);
            tick();
            chkb("cs_k2", avm_chipselect, 1'b1);
            chkb("wn_rd_k2", avm_write_n, 1'b1);
            chkw("addr_k2", 32'(avm_address), 32'(op[0]));
            chkb("rsp_k2", rsp_valid, 1'b0);
            tick();
            chkb("rsp_valid_k3", rsp_valid, 1'b1);
            chkb("rsp_data_k3", rsp_data, exp);
            chkb("ready_k3", cmd_ready, 1'b1);
            chkb("cs_k3", avm_chipselect, 1'b0);
            tick();
            chkb("rsp_valid_k4", rsp_valid, 1'b0);
        end
    endtask

    task automatic wait_rd_start();
        int n = 0;
        while (!(avm_chipselect && avm_write_n) && n < 60) begin
            tick();
            n++;
        end
        chkb("poll_start_timeout", n < 60, 1'b1);
        chkw("poll_addr", 32'(avm_address), 32'd0);
    endtask

    task automatic wait_poll();
        int n = 0;
        wait_rd_start();
        while (avm_chipselect && n < 5) begin
            tick();
            n++;
        end
        chkb("poll_end_timeout", n < 5, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int bad;
        int base;
        int c;
        logic done;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_wdata   = 1'b0;
        poll_en     = 1'b0;
        poll_period = 16'd0;
        irq_clear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chkb("rst_ready", cmd_ready, 1'b1);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chkb("rst_rsp_data", rsp_data, 1'b0);
        chkb("rst_irq", edge_irq, 1'b0);
        chkb("rst_cs", avm_chipselect, 1'b0);
        chkb("rst_wn", avm_write_n, 1'b1);
        chkw("rst_addr", 32'(avm_address), 32'd0);
        chkw("rst_wdata", avm_writedata, 32'd0);
        tick();

        do_cmd(2'b01, 1'b1);
        pin = 1'b1;
        do_cmd(2'b10, 1'b0);

        for (int i = 0; i < 40; i++) begin
            pin = 1'($urandom);
            do_cmd(2'($urandom), 1'($urandom));
        end
        chkb("slave_data_reg", data_reg, data_m);
        chkb("slave_dir_reg", dir_reg, dir_m);
        chkw("rsp_count", 32'(rsp_cnt), 32'(rd_m));

        pin         = 1'b0;
        poll_period = 16'd4;
        poll_en     = 1'b1;
        wait_poll();
        chkb("irq_first_poll", edge_irq, 1'b0);
        pin = 1'b1;
        wait_poll();
        chkb("irq_after_toggle", edge_irq, 1'b1);
        chkw("poll_no_rsp", 32'(rsp_cnt), 32'(rd_m));
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chkb("irq_cleared", edge_irq, 1'b0);

        pin = 1'b0;
        wait_rd_start();
        tick();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chkb("irq_set_wins", edge_irq, 1'b1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chkb("irq_clear2", edge_irq, 1'b0);

        poll_en = 1'b0;
        repeat (6) tick();
        poll_period = 16'd6;
        poll_en     = 1'b1;
        cmd_op      = 2'b11;
        cmd_valid   = 1'b1;
        acc  = 0;
        bad  = 0;
        c    = 0;
        done = 1'b0;
        base = rsp_cnt;
        while (!done && c < 60) begin
            if (avm_chipselect && avm_address == 2'd0) bad++;
            if (cmd_ready && c >= 18) begin
                cmd_valid = 1'b0;
                done = 1'b1;
            end else begin
                if (cmd_ready) acc++;
                tick();
                c++;
            end
        end
        chkb("stream_end_reached", done, 1'b1);
        chkw("no_poll_during_stream", 32'(bad), 32'd0);
        tick();
        chkb("poll_after_stream_cs", avm_chipselect, 1'b1);
        chkb("poll_after_stream_wn", avm_write_n, 1'b1);
        chkw("poll_after_stream_addr", 32'(avm_address), 32'd0);
        repeat (3) tick();
        chkw("stream_rsp_count", 32'(rsp_cnt - base), 32'(acc));

        poll_en = 1'b0;
        repeat (6) tick();
        base      = rsp_cnt;
        cmd_op    = 2'b10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chkb("pre_rst_rd_cs", avm_chipselect, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        chkb("abort_rsp_valid", rsp_valid, 1'b0);
        chkb("abort_rsp_data", rsp_data, 1'b0);
        chkb("abort_cs", avm_chipselect, 1'b0);
        chkb("abort_wn", avm_write_n, 1'b1);
        chkw("abort_addr", 32'(avm_address), 32'd0);
        chkw("abort_wdata", avm_writedata, 32'd0);
        chkb("abort_irq", edge_irq, 1'b0);
        chkb("abort_ready", cmd_ready, 1'b1);
        reset = 1'b0;
        repeat (3) tick();
        chkw("abort_no_rsp", 32'(rsp_cnt), 32'(base));
        chkb("abort_bus_idle", avm_chipselect, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_avmm_master.md
PIO_AVMM_MASTER -- requirements
Module: pio_avmm_master

Interface
REQ-001 Parameter POLL_W, default 16, width of the poll-period counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 cmd_op  input  2  00 write data reg, 01 write dir reg, 10 read data (addr 0), 11 read dir (addr 1).
REQ-007 cmd_wdata  input  1  bit written for ops 00/01.
REQ-008 rsp_valid  output  1  one-cycle pulse carrying a read result.
REQ-009 rsp_data  output  1  read result bit.
REQ-010 poll_en  input  1  enables background polling of the pin.
REQ-011 poll_period  input  POLL_W  clocks between polls; 0 disables polling.
REQ-012 edge_irq  output  1  sticky pin-change flag.
REQ-013 irq_clear  input  1  clears edge_irq.
REQ-014 avm_address  output  2  Avalon-MM address to the PIO slave.
REQ-015 avm_chipselect  output  1  slave select.
REQ-016 avm_write_n  output  1  active-low write strobe.
REQ-017 avm_writedata  output  32  {31'b0, bit}.
REQ-018 avm_readdata  input  32  slave readdata, registered in the slave (one-cycle read latency, no waitrequest); only bit 0 used.

Function
REQ-019 FSM states SHALL be IDLE, WR, RD_ADDR, RD_CAP; cmd_ready SHALL equal (state==IDLE).
REQ-020 Commands SHALL have priority over polls; a due poll SHALL start only from IDLE with cmd_valid low.
REQ-021 Write accepted in cycle k: WR in k+1 with chipselect=1, write_n=0, address=cmd_op[0], writedata=cmd_wdata; IDLE in k+2; no response.
REQ-022 Read accepted in cycle k: RD_ADDR in k+1, RD_CAP in k+2, chipselect=1, write_n=1, address held constant both cycles; avm_readdata[0] sampled at end of k+2.
REQ-023 Command read: rsp_valid=1, rsp_data=sampled bit in k+3 only, state IDLE in k+3; rsp has no backpressure.
REQ-024 Outside WR/RD_ADDR/RD_CAP: chipselect=0, write_n=1, address=0, writedata=0.
REQ-025 Poll timer: down-counter reloaded with poll_period when it hits 0 or when poll_en is low; on reaching 0 with poll_en=1 and poll_period!=0, set poll_pending; pending SHALL be held until the poll read starts, further expiries while pending are merged.
REQ-026 Poll read: same bus sequence as REQ-022 on address 0; produces no rsp_valid.
REQ-027 First poll after reset or after poll_en rising SHALL only load last_sample; subsequent polls SHALL set edge_irq when sampled bit != last_sample, then update last_sample.
REQ-028 Command reads of address 0 SHALL NOT update last_sample or edge_irq.
REQ-029 irq_clear SHALL clear edge_irq next cycle; simultaneous set and clear: set wins.
REQ-030 Changing cmd_op/cmd_wdata while not accepted SHALL have no effect; inputs captured at acceptance.

Reset
REQ-031 Reset SHALL force: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, edge_irq=0, poll_pending=0, counter=poll_period, first-poll flag set, bus outputs idle per REQ-024.
REQ-032 Reset asserted mid-transaction SHALL abort it with no response and no bus strobe in the following cycle.

Structure
REQ-033 Shared package SHALL hold the cmd_op encodings, PIO address constants (DATA=0, DIR=1) and the FSM state enum.
REQ-034 Poll timer SHALL be one sub-module, pio_poll_timer (counter, reload, pending flag).

Verification
REQ-035 Write dir=1 (op 01, wdata 1) -> one cycle chipselect=1, write_n=0, address=1, writedata=1; cmd_ready low exactly one cycle.
REQ-036 With slave pin driven 1, read op 10 accepted cycle k -> address 0 held k+1..k+2, rsp_valid=1, rsp_data=1 in k+3 only.
REQ-037 poll_period=4, pin toggles 0->1 after first poll -> no irq on first poll, edge_irq=1 after next poll; irq_clear -> 0.
REQ-038 cmd_valid held high continuously while poll due -> commands serviced back-to-back, poll starts the first IDLE cycle cmd_valid drops.
REQ-039 Reset asserted in RD_CAP -> no rsp_valid, bus idle next cycle, all outputs at reset values.
REQ-040 irq_clear coincident with edge detection -> edge_irq remains 1.
